reg16_op_sequencer: RTL and testbench
=====================================

// Module: reg16_op_sequencer
// PURPOSE
//  Sequenced 16-bit working register: accepts one op per valid/ready handshake
//  (load, clear, inc, dec, multi-cycle shift/rotate) and holds the result.
//  Drives the 3-bit status code SZero/SOne/STwo consumed directly by the
//  downstream display-line decoder in the sixteen_bit_register group.
// PARAMETERS
//  WIDTH   16  register width (status/wrap rules written for 16; must stay >=2)
//  AMT_W   4   width of Amount; max shift count 2**AMT_W-1
// PORTS
//  Clk      in   1      single clock, all state on rising edge
//  ResetN   in   1      synchronous, active-low reset
//  InValid  in   1      op request valid
//  InReady  out  1      block can accept op (high only in IDLE)
//  Op       in   3      000 NOP,001 LOAD,010 CLEAR,011 SHL,100 SHR,101 ROL,110 INC,111 DEC
//  Amount   in   AMT_W  shift/rotate count (SHL/SHR/ROL only; ignored otherwise)
//  DataIn   in   WIDTH  LOAD operand
//  DataOut  out  WIDTH  register contents
//  CarryOut out  1      carry/borrow/last bit out of most recent op
//  Busy     out  1      high in SHIFT state
//  Done     out  1      one-cycle pulse in DONE state
//  SZero    out  1      status code bit 0 (to decoder)
//  SOne     out  1      status code bit 1
//  STwo     out  1      status code bit 2
// BEHAVIOUR
//  Reset (ResetN=0 at edge, overrides everything incl. mid-shift): state=IDLE,
//   DataOut=0, CarryOut=0, shift counter=0; outputs: InReady=1, Busy=0,
//   Done=0, status code {STwo,SOne,SZero}=3'b001.
//  FSM states IDLE, SHIFT, DONE. InReady=(state==IDLE). Accept = InValid&InReady.
//  IDLE, accept of NOP/LOAD/CLEAR/INC/DEC, or SHL/SHR/ROL with Amount=0:
//   register/CarryOut update at accept edge; next state DONE.
//   NOP: no change, CarryOut kept. LOAD: DataOut<=DataIn, Carry<=0.
//   CLEAR: DataOut<=0, Carry<=0. Shift with Amount=0: no change, Carry<=0.
//   INC: DataOut+1 mod 2^16, Carry<=1 iff 0xFFFF->0x0000.
//   DEC: DataOut-1 mod 2^16, Carry<=1 iff 0x0000->0xFFFF.
//  IDLE, accept of SHL/SHR/ROL with Amount=N>0: latch Op, counter<=N, no
//   register change at accept edge; next state SHIFT.
//  SHIFT: each cycle shift/rotate by one bit, counter-=1; when counter==1
//   the final step occurs and next state DONE. Exactly N cycles in SHIFT.
//   SHL: Carry<=old MSB, LSB<=0. SHR logical: Carry<=old LSB, MSB<=0.
//   ROL: MSB->LSB, Carry<=old MSB. Carry reflects last step only.
//  DONE: Done=1 for exactly one cycle; unconditionally -> IDLE.
//  Latency accept->Done: 1 cycle (single-step ops), N+1 cycles (shifts).
//   Max throughput one op per 2 cycles.
//  Op/Amount/DataIn/InValid ignored outside IDLE; no queueing.
//  Status code (combinational from registered state, priority order):
//   SHIFT ->3'b010; DONE ->3'b011; IDLE&CarryOut ->3'b100;
//   IDLE&DataOut==0 ->3'b001; else 3'b000.
// TESTING
//  Reset then LOAD 0x1234 -> InReady low 1 cycle, Done pulse next cycle,
//   DataOut=0x1234, Carry=0, code 011 then 000.
//  LOAD 0xFFFF, INC -> DataOut=0x0000, Carry=1, idle code 100; DEC -> 0xFFFF, Carry=1.
//  LOAD 0x8001, SHL Amount=3 -> Busy 3 cycles (code 010), DataOut=0x0008,
//   Carry=0 (last bit out), Done on 4th cycle after accept.
//  LOAD 0x8001, ROL Amount=1 -> 0x0003, Carry=1; SHR Amount=0 -> no change,
//   Carry=0, Done 1 cycle after accept.
//  SHL Amount=15 on 0x0001 with ResetN low in 5th SHIFT cycle -> next cycle
//   IDLE, DataOut=0, code 001, InReady=1.
//  InValid held high with toggling Op during SHIFT/DONE -> ignored; new op
//   accepted only on first IDLE cycle.

Source files
------------

// File: rtl/reg16_op_sequencer.sv
// reg16_op_sequencer
//   Sequenced working register. Accepts one operation per InValid/InReady
//   handshake (NOP, LOAD, CLEAR, INC, DEC, and multi-cycle SHL/SHR/ROL),
//   holds the result, and drives a 3-bit status code for the downstream
//   display-line decoder.
//
// Ports
//   Clk       clock; all state updates on the rising edge
//   ResetN    synchronous active-low reset
//   InValid   op request valid
//   InReady   high only in IDLE; an op is accepted on InValid & InReady
//   Op        000 NOP, 001 LOAD, 010 CLEAR, 011 SHL, 100 SHR, 101 ROL,
//             110 INC, 111 DEC
//   Amount    shift/rotate count (SHL/SHR/ROL only)
//   DataIn    LOAD operand
//   DataOut   register contents
//   CarryOut  carry/borrow/last bit out of the most recent op
//   Busy      high while shifting
//   Done      one-cycle completion pulse
//   SZero/SOne/STwo  status code bits 0/1/2

module reg16_op_sequencer #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             Clk,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       Op,
    input  logic [AMT_W-1:0] Amount,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataOut,
    output logic             CarryOut,
    output logic             Busy,
    output logic             Done,
    output logic             SZero,
    output logic             SOne,
    output logic             STwo
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_SHR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_INC   = 3'b110;
    localparam logic [2:0] OP_DEC   = 3'b111;

    logic [1:0]       state;
    logic [AMT_W-1:0] count;
    logic [2:0]       shift_op;
    logic [WIDTH-1:0] data;
    logic             carry;
    logic             accept;
    logic             is_shift;
    logic [2:0]       status;

    assign InReady  = (state == ST_IDLE);
    assign Busy     = (state == ST_SHIFT);
    assign Done     = (state == ST_DONE);
    assign DataOut  = data;
    assign CarryOut = carry;
    assign accept   = InValid & InReady;
    assign is_shift = (Op == OP_SHL) || (Op == OP_SHR) || (Op == OP_ROL);

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            state    <= ST_IDLE;
            data     <= '0;
            carry    <= 1'b0;
            count    <= '0;
            shift_op <= OP_NOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_shift && (Amount != '0)) begin
                            // Register is untouched at accept; the N steps
                            // all happen in SHIFT.
                            shift_op <= Op;
                            count    <= Amount;
                            state    <= ST_SHIFT;
                        end else begin
                            state <= ST_DONE;
                            case (Op)
                                OP_LOAD: begin
                                    data  <= DataIn;
                                    carry <= 1'b0;
                                end
                                OP_CLEAR: begin
                                    data  <= '0;
                                    carry <= 1'b0;
                                end
                                OP_SHL, OP_SHR, OP_ROL: begin
                                    carry <= 1'b0;
                                end
                                OP_INC: begin
                                    data  <= data + WIDTH'(1);
                                    carry <= (data == '1);
                                end
                                OP_DEC: begin
                                    data  <= data - WIDTH'(1);
                                    carry <= (data == '0);
                                end
                                default: begin
                                    // NOP: register and carry held
                                end
                            endcase
                        end
                    end
                end
                ST_SHIFT: begin
                    case (shift_op)
                        OP_SHL: begin
                            carry <= data[WIDTH-1];
                            data  <= {data[WIDTH-2:0], 1'b0};
                        end
                        OP_SHR: begin
                            carry <= data[0];
                            data  <= {1'b0, data[WIDTH-1:1]};
                        end
                        default: begin
                            carry <= data[WIDTH-1];
                            data  <= {data[WIDTH-2:0], data[WIDTH-1]};
                        end
                    endcase
                    count <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Priority: SHIFT, DONE, idle-with-carry, idle-with-zero.
    always_comb begin
        status = 3'b000;
        if (state == ST_SHIFT) begin
            status = 3'b010;
        end else if (state == ST_DONE) begin
            status = 3'b011;
        end else if ((state == ST_IDLE) && carry) begin
            status = 3'b100;
        end else if ((state == ST_IDLE) && (data == '0)) begin
            status = 3'b001;
        end
    end

    assign {STwo, SOne, SZero} = status;

endmodule

// File: tb/tb_reg16_op_sequencer.sv
// tb_reg16_op_sequencer
//   Directed scoreboard bench for reg16_op_sequencer. Stimulus pushes the
//   hand-computed result and accept->Done distance of each op; a monitor
//   pops and compares on every Done pulse.

module tb_reg16_op_sequencer;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_SHR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_INC   = 3'b110;
    localparam logic [2:0] OP_DEC   = 3'b111;

    logic        Clk = 1'b0;
    logic        ResetN;
    logic        InValid;
    logic        InReady;
    logic [2:0]  Op;
    logic [3:0]  Amount;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        CarryOut;
    logic        Busy;
    logic        Done;
    logic        SZero;
    logic        SOne;
    logic        STwo;
    logic [2:0]  code;

    assign code = {STwo, SOne, SZero};

    reg16_op_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
        .Clk      (Clk),
        .ResetN   (ResetN),
        .InValid  (InValid),
        .InReady  (InReady),
        .Op       (Op),
        .Amount   (Amount),
        .DataIn   (DataIn),
        .DataOut  (DataOut),
        .CarryOut (CarryOut),
        .Busy     (Busy),
        .Done     (Done),
        .SZero    (SZero),
        .SOne     (SOne),
        .STwo     (STwo)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] d;
        logic        c;
        int          off;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (ResetN && Done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_data", {16'd0, DataOut}, {16'd0, e.d});
                chk("done_carry", {31'd0, CarryOut}, {31'd0, e.c});
                chk("done_latency", cyc - e.acc, e.off);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] amt, input logic [15:0] din,
                         input bit push, input logic [15:0] ed, input logic ec, input int off);
        int n;
        exp_t e;
        n = 0;
        while (!InReady && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
        InValid = 1'b1;
        Op      = op;
        Amount  = amt;
        DataIn  = din;
        if (push) begin
            e.d = ed; e.c = ec; e.off = off; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge Clk);
        InValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        ResetN = 1'b0; InValid = 1'b0; Op = OP_NOP; Amount = '0; DataIn = '0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_data", {16'd0, DataOut}, 32'h0);
        chk("rst_carry", {31'd0, CarryOut}, 32'd0);
        chk("rst_ready", {31'd0, InReady}, 32'd1);
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_code", {29'd0, code}, 32'd1);
        ResetN = 1'b1;

        issue(OP_LOAD, 4'd0, 16'h1234, 1, 16'h1234, 1'b0, 0);
        chk("load_code_done", {29'd0, code}, 32'd3);
        chk("load_ready_low", {31'd0, InReady}, 32'd0);
        @(negedge Clk);
        chk("load_code_idle", {29'd0, code}, 32'd0);
        chk("load_ready_high", {31'd0, InReady}, 32'd1);

        issue(OP_LOAD, 4'd0, 16'hFFFF, 1, 16'hFFFF, 1'b0, 0);
        issue(OP_INC,  4'd7, 16'h0000, 1, 16'h0000, 1'b1, 0);
        @(negedge Clk);
        chk("inc_code_carry", {29'd0, code}, 32'd4);
        issue(OP_DEC,  4'd0, 16'h0000, 1, 16'hFFFF, 1'b1, 0);

        issue(OP_LOAD, 4'd0, 16'h8001, 1, 16'h8001, 1'b0, 0);
        issue(OP_SHL,  4'd3, 16'h0000, 1, 16'h0008, 1'b0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("shl_busy", {31'd0, Busy}, 32'd1);
            chk("shl_code", {29'd0, code}, 32'd2);
            @(negedge Clk);
        end

        issue(OP_LOAD, 4'd0, 16'h8001, 1, 16'h8001, 1'b0, 0);
        issue(OP_ROL,  4'd1, 16'h0000, 1, 16'h0003, 1'b1, 1);
        issue(OP_SHR,  4'd0, 16'h0000, 1, 16'h0003, 1'b0, 0);

        issue(OP_LOAD, 4'd0, 16'h0018, 1, 16'h0018, 1'b0, 0);
        issue(OP_SHR,  4'd4, 16'h0000, 1, 16'h0001, 1'b1, 4);
        issue(OP_NOP,  4'd0, 16'hBEEF, 1, 16'h0001, 1'b1, 0);
        issue(OP_CLEAR,4'd0, 16'hBEEF, 1, 16'h0000, 1'b0, 0);
        @(negedge Clk);
        chk("clear_code_zero", {29'd0, code}, 32'd1);

        // Requests during SHIFT/DONE must be ignored.
        issue(OP_LOAD, 4'd0, 16'hC000, 1, 16'hC000, 1'b0, 0);
        issue(OP_SHL,  4'd2, 16'h0000, 1, 16'h0000, 1'b1, 2);
        n = 0;
        while (!InReady && n < 20) begin
            InValid = 1'b1;
            Op      = (n % 2 == 1) ? OP_CLEAR : OP_LOAD;
            DataIn  = 16'hDEAD;
            @(negedge Clk);
            n++;
        end
        chk("ignored_cycles", n, 32'd3);
        issue(OP_LOAD, 4'd0, 16'h5A5A, 1, 16'h5A5A, 1'b0, 0);

        // Reset in the 5th SHIFT cycle of a 15-step shift.
        issue(OP_LOAD, 4'd0, 16'h0001, 1, 16'h0001, 1'b0, 0);
        issue(OP_SHL,  4'd15, 16'h0000, 0, 16'h0000, 1'b0, 0);
        repeat (4) @(negedge Clk);
        chk("midshift_busy", {31'd0, Busy}, 32'd1);
        chk("midshift_data", {16'd0, DataOut}, 32'h0010);
        ResetN = 1'b0;
        @(negedge Clk);
        chk("abort_data", {16'd0, DataOut}, 32'h0);
        chk("abort_code", {29'd0, code}, 32'd1);
        chk("abort_ready", {31'd0, InReady}, 32'd1);
        chk("abort_busy", {31'd0, Busy}, 32'd0);
        ResetN = 1'b1;
        issue(OP_INC, 4'd0, 16'h0000, 1, 16'h0001, 1'b0, 0);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("scoreboard_drained", sb.size(), 32'd0);
        repeat (3) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
